// File: rtl/addsub_pkg.sv
// addsub_pkg: shared definitions for the pipelined adder/subtractor.
//   OP_ADD / OP_SUB : values of the 'sub' mode input.
//   num_stages()    : pipeline depth (and latency) for a given WIDTH/CHUNK.
//   full_add()      : one-bit full adder, returns {carry, sum}.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // A bad CHUNK is rejected at elaboration by the top. Returning 1 here
    // just keeps this function from dividing by zero before that happens.
    function automatic int num_stages(input int width, input int chunk);
        return (chunk < 1) ? 1 : (width / chunk);
    endfunction

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic s;
        logic co;
        s  = x ^ y ^ ci;
        co = (x & y) | (ci & (x ^ y));
        return {co, s};
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// addsub_chunk: combinational CHUNK-bit ripple adder made of full adders.
//   a, b  : chunk operands (b already inverted by the caller for subtract)
//   ci    : carry into bit 0 of the chunk
//   s     : chunk sum
//   co    : carry out of the chunk MSB
//   cmsb  : carry into the chunk MSB (signed-overflow detection)
module addsub_chunk
    import addsub_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             cmsb
);

    logic       carry;
    logic [1:0] fa;

    always_comb begin
        s     = '0;
        cmsb  = 1'b0;
        fa    = '0;
        carry = ci;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) cmsb = carry;
            fa    = full_add(a[i], b[i], carry);
            s[i]  = fa[0];
            carry = fa[1];
        end
        co = carry;
    end

endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: two's-complement adder/subtractor split into WIDTH/CHUNK
// ripple chunks, one pipeline stage per chunk, with the carry registered
// between stages. Latency NUM_STAGES, throughput one operation per cycle.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : operand handshake (in_ready = !stall)
//   a, b, cin, sub      : operands; sub=1 computes a + ~b + cin
//   out_valid/out_ready : result handshake
//   sum, carryout       : result and carry out of the MSB (1 = no borrow in sub)
//   overflow, zero      : signed overflow and sum == 0
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int NUM_STAGES = num_stages(WIDTH, CHUNK);

    if (CHUNK < 1) begin : g_bad_chunk
        $error("pipelined_addsub: CHUNK must be at least 1");
    end else if (WIDTH % CHUNK != 0) begin : g_bad_width
        $error("pipelined_addsub: WIDTH must be a multiple of CHUNK");
    end

    // vld_pipe[k] is the valid bit of stage k-1's register; the top bit is out_valid.
    logic [NUM_STAGES:1] vld_pipe;
    logic                stall;
    logic                accept;

    // Inputs seen by each stage's chunk adder. Entry 0 comes from the ports,
    // entry k from the register of stage k-1.
    wire [NUM_STAGES-1:0][WIDTH-1:0] a_in;
    wire [NUM_STAGES-1:0][WIDTH-1:0] b_in;
    wire [NUM_STAGES-1:0]            c_in;

    assign out_valid = vld_pipe[NUM_STAGES];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign accept    = in_valid && in_ready;

    assign a_in[0] = a;
    assign b_in[0] = (sub == OP_SUB) ? ~b : b;
    assign c_in[0] = cin;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else if (!stall) begin
            vld_pipe <= NUM_STAGES'({vld_pipe, accept});
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_st
        localparam int LO = k * CHUNK;

        logic [CHUNK-1:0] ch_s;
        logic             ch_co;
        logic             ch_cm;
        logic [WIDTH-1:0] a_nxt;
        logic [WIDTH-1:0] a_q;
        logic             c_q;

        addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a    (a_in[k][LO +: CHUNK]),
            .b    (b_in[k][LO +: CHUNK]),
            .ci   (c_in[k]),
            .s    (ch_s),
            .co   (ch_co),
            .cmsb (ch_cm)
        );

        // The A word doubles as the skewed result: chunks below k already hold
        // sum bits, chunk k is overwritten here, chunks above still hold A.
        // After the last stage the whole word is the sum.
        always_comb begin
            a_nxt              = a_in[k];
            a_nxt[LO +: CHUNK] = ch_s;
        end

        // Data registers load on every unstalled edge; contents of a bubble
        // are don't-care.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                a_q <= '0;
                c_q <= 1'b0;
            end else if (!stall) begin
                a_q <= a_nxt;
                c_q <= ch_co;
            end
        end

        if (k < NUM_STAGES - 1) begin : g_mid
            logic [WIDTH-1:0] b_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    b_q <= '0;
                end else if (!stall) begin
                    b_q <= b_in[k];
                end
            end

            assign a_in[k+1] = a_q;
            assign b_in[k+1] = b_q;
            assign c_in[k+1] = c_q;
        end else begin : g_last
            logic ovf_q;
            logic zero_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (!stall) begin
                    ovf_q  <= ch_cm ^ ch_co;
                    zero_q <= ~|a_nxt;
                end
            end

            assign sum      = a_q;
            assign carryout = c_q;
            assign overflow = ovf_q;
            assign zero     = zero_q;
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed + short random test of pipelined_addsub
// (WIDTH=32, CHUNK=8). Expected results are queued at acceptance and
// compared in order when the result transfers out.
module tb_pipelined_addsub;

    localparam int W   = 32;
    localparam int CH  = 8;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         carryout;
    logic         overflow;
    logic         zero;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(W), .CHUNK(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carryout  (carryout),
        .overflow  (overflow),
        .zero      (zero)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        logic         ov;
        logic         z;
        int           t;
    } exp_t;

    exp_t         q[$];
    exp_t         nxt;
    int           total = 0;
    int           bad = 0;
    int           cyc_n = 0;
    bit           check_lat = 1'b1;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_sum = '0;
    logic [2:0]   prev_flags = '0;

    // Reference: 33-bit sum for carry out, 31-bit low sum for carry into MSB.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
        exp_t         r;
        logic [W-1:0] be;
        logic [W:0]   full;
        logic [W-1:0] low;
        be    = s ? ~y : y;
        full  = {1'b0, x} + {1'b0, be} + (W+1)'(c);
        low   = {1'b0, x[W-2:0]} + {1'b0, be[W-2:0]} + W'(c);
        r.sum = full[W-1:0];
        r.co  = full[W];
        r.ov  = low[W-1] ^ full[W];
        r.z   = (full[W-1:0] == '0);
        r.t   = 0;
        return r;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] s, input logic co, input logic ov, input logic z);
        exp_t r;
        r.sum = s; r.co = co; r.ov = ov; r.z = z; r.t = 0;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
        a = x; b = y; cin = c; sub = s;
    endtask

    // One clock: sample at the falling edge, then step past the rising edge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (prev_stall) begin
                chk("hold_sum", sum, prev_sum);
                chk("hold_flags", {29'b0, carryout, overflow, zero}, {29'b0, prev_flags});
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
            end
            if (out_valid && q.size() == 0) begin
                chk("spurious_valid", {31'b0, out_valid}, 32'd0);
            end else if (out_valid && out_ready) begin
                e = q.pop_front();
                chk("sum", sum, e.sum);
                chk("carryout", {31'b0, carryout}, {31'b0, e.co});
                chk("overflow", {31'b0, overflow}, {31'b0, e.ov});
                chk("zero", {31'b0, zero}, {31'b0, e.z});
                if (check_lat) chk("latency", 32'(cyc_n - e.t), 32'(LAT));
            end
            if (in_valid && in_ready) begin
                e   = nxt;
                e.t = cyc_n;
                q.push_back(e);
            end
            prev_stall = out_valid && !out_ready;
            prev_sum   = sum;
            prev_flags = {carryout, overflow, zero};
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic drain();
        for (int g = 0; g < 40 && q.size() > 0; g++) cyc();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_sum"}, sum, 32'd0);
        chk({tag, "_carryout"}, {31'b0, carryout}, 32'd0);
        chk({tag, "_overflow"}, {31'b0, overflow}, 32'd0);
        chk({tag, "_zero"}, {31'b0, zero}, 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc, rs, acc;
        int           n;

        // Reset state
        rst_n = 1'b0;
        cyc(); cyc();
        chk_reset_state("reset");
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;

        // Directed corner cases, back to back, fixed latency
        check_lat = 1'b1;
        in_valid  = 1'b1;
        set_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); nxt = mk(32'h0000_0000, 1'b1, 1'b0, 1'b1); cyc();
        set_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); nxt = mk(32'h8000_0000, 1'b0, 1'b1, 1'b0); cyc();
        set_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1); nxt = mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0); cyc();
        set_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1); nxt = mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0); cyc();
        in_valid = 1'b0;
        drain();

        // Full throughput: 8 ops on consecutive cycles
        for (int t = 0; t < 12; t++) begin
            in_valid = (t < 8);
            set_op(W'(t), W'(t), 1'b0, 1'b0);
            nxt = mk(W'(2 * t), 1'b0, 1'b0, (t == 0));
            #1;
            if (t < 8) chk("thru_in_ready", {31'b0, in_ready}, 32'd1);
            cyc();
        end
        in_valid = 1'b0;
        drain();

        // Same stream with the consumer stalled on cycles 5-9
        check_lat = 1'b0;
        n = 0;
        for (int t = 0; t < 30; t++) begin
            out_ready = !(t >= 5 && t <= 9);
            in_valid  = (n < 8);
            set_op(W'(n), W'(n), 1'b0, 1'b0);
            nxt = mk(W'(2 * n), 1'b0, 1'b0, (n == 0));
            #1;
            acc = in_valid && in_ready;
            if (t >= 5 && t <= 9) chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            cyc();
            if (acc) n++;
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        chk("stall_accepted", 32'(n), 32'd8);
        drain();

        // Random ops with random backpressure
        n  = 0;
        ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
        for (int g = 0; g < 200 && n < 20; g++) begin
            in_valid = 1'b1;
            set_op(ra, rb, rc, rs);
            nxt = model(ra, rb, rc, rs);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            acc = in_ready;
            cyc();
            if (acc) begin
                n++;
                ra = $urandom; rb = $urandom;
                if (n % 5 == 0) rb = ra;
                rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("rand_accepted", 32'(n), 32'd20);
        drain();

        // Reset with three operations in flight
        check_lat = 1'b1;
        in_valid  = 1'b1;
        set_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); nxt = model(a, b, cin, sub); cyc();
        set_op(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0); nxt = model(a, b, cin, sub); cyc();
        set_op(32'h0000_0009, 32'h0000_0003, 1'b1, 1'b1); nxt = model(a, b, cin, sub); cyc();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        cyc();
        q.delete();
        chk_reset_state("midreset");
        rst_n = 1'b1;
        for (int t = 0; t < 8; t++) cyc();
        chk("post_reset_idle", {31'b0, out_valid}, 32'd0);
        in_valid = 1'b1;
        set_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        nxt = mk(32'h2345_6789, 1'b0, 1'b0, 1'b0);
        cyc();
        in_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor. Successor to the single-bit full adders.
- Splits a WIDTH-bit operation into WIDTH/CHUNK ripple chunks, one pipeline stage per chunk, with the carry registered between stages.
- Accepts one operation per cycle through a valid/ready handshake and flags carry, signed overflow and zero.
- Serves as the arithmetic core for the ALU and multi-word datapaths.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per pipeline stage. NUM_STAGES = WIDTH/CHUNK, which is also the latency.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in. Drive 1 for a plain subtraction; used for multi-word chaining.
- sub  input  1  0 gives a+b+cin; 1 gives a+~b+cin.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- carryout  output  1  carry out of the MSB. In sub mode, 1 means no borrow.
- overflow  output  1  signed overflow.
- zero  output  1  sum == 0.

Behaviour:
- Reset: on a clk edge with rst_n=0, all stage valid bits clear, and out_valid, sum, carryout, overflow and zero all become 0. The reset edge accepts no transaction. Reset mid-operation discards every in-flight operation; nothing emerges afterwards.
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready. The whole pipeline holds while stalled and in_ready = !stall. in_ready is combinational from out_ready.
- While stalled: sum, carryout, overflow and zero stay stable, and out_valid stays high.
- Stage 0 on accept: registers a, the effective operand beff = sub ? ~b : b, and the chunk-0 partial sum with cin; its carry goes into stage register c[0].
- Stage k (1..NUM_STAGES-1): adds chunk k of a and beff plus c[k-1], registers that chunk's sum and carry, and passes the already-computed lower chunks and the unprocessed upper operand chunks along (skewed pipeline).
- A stage advances when not stalled. Bubbles (valid=0) propagate; register contents in a bubble are don't-care.
- Latency: the result is valid exactly NUM_STAGES cycles after acceptance, absent stall.
- Throughput: 1 operation per cycle. Order is always preserved.
- Flags, computed in the final stage:
  - carryout = carry out of bit WIDTH-1.
  - overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - zero = ~|sum.
- Arithmetic is modulo 2^WIDTH. No saturation.
- Simultaneous input and output transfer in the same cycle is legal and required for full throughput.
- NUM_STAGES=1 is legal: a single registered stage with latency 1.
- Elaboration fails if WIDTH % CHUNK != 0 or CHUNK < 1.

Decomposition:
- Shared package addsub_pkg: op-mode constants OP_ADD=1'b0 and OP_SUB=1'b1, and a function computing NUM_STAGES from WIDTH and CHUNK.
- One sub-module, addsub_chunk: combinational CHUNK-bit ripple adder built from the structural full adder. Outputs the chunk sum, carry out, and carry into the chunk MSB (needed for overflow).
- addsub_chunk is instantiated once per stage in a generate loop; the top holds the registers and the handshake.

Test Plan (WIDTH=32, CHUNK=8, latency 4):
- 0xFFFFFFFF + 0x00000001 (sub=0, cin=0) -> 4 cycles later: sum 0x00000000, carryout 1, overflow 0, zero 1.
- 0x7FFFFFFF + 0x00000001 (sub=0, cin=0) -> sum 0x80000000, carryout 0, overflow 1, zero 0.
- 5 - 7 (sub=1, cin=1) -> sum 0xFFFFFFFE, carryout 0 (borrow), overflow 0. Then 0x80000000 - 1 (sub=1, cin=1) -> sum 0x7FFFFFFF, carryout 1, overflow 1.
- 8 back-to-back inputs a=i, b=i (i=0..7) with out_ready=1 -> in_ready stays 1; results 0,2,...,14 appear on consecutive cycles from cycle 4.
- Same 8 inputs with out_ready=0 during cycles 5-9 -> in_ready=0 during the stall, outputs held stable, no loss or duplication, order preserved once out_ready=1.
- 3 operations in flight, then rst_n=0 for one edge -> next cycle out_valid=0 with all outputs 0; no stale result appears later; a new operation after reset completes with latency 4.
